// File: rtl/cache_types_pkg.sv
// rtl/cache_types_pkg.sv - shared types and constants for the cache sequencer
package cache_types_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_t;

    localparam logic [1:0] WAYSEL_HIT  = 2'b00;
    localparam logic [1:0] WAYSEL_LRU  = 2'b01;
    localparam logic [1:0] WAYSEL_WAY0 = 2'b10;

    localparam int OFFSET_W = 5;
    localparam int SET_W    = 3;
    localparam int TAG_W    = 24;

endpackage

// File: rtl/cache_control_if.sv
// rtl/cache_control_if.sv - CPU request and physical memory bus bundle
interface cache_control_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_byte_enable256;
    logic        mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic        pmem_resp;
    logic [31:0] pmem_address;

    modport master (
        output mem_read, mem_write, mem_address, mem_byte_enable256, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, pmem_address
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_byte_enable256, pmem_resp,
        output mem_resp, pmem_read, pmem_write, pmem_address
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/cache_control.sv
// rtl/cache_control.sv - hit/writeback/fill sequencer for the 2-way cache
module cache_control
    import cache_types_pkg::*;
#(
    parameter int S_COUNT = 32
) (
    input  logic               clk,
    input  logic               rst,
    cache_control_if.slave     bus,
    input  logic               cache_hit,
    input  logic               dirty_dataout,
    input  logic [TAG_W-1:0]   tag_dataout,
    output logic               data_read,
    output logic               tag_read,
    output logic               valid_read,
    output logic               dirty_read,
    output logic               lru_read,
    output logic               comb_data_read,
    output logic               comb_tag_read,
    output logic               comb_valid_read,
    output logic               comb_dirty_read,
    output logic               tag_load,
    output logic               valid_load,
    output logic               valid_datain,
    output logic               dirty_load,
    output logic               dirty_datain,
    output logic               lru_load,
    output logic [1:0]         way_index_sel,
    output logic [31:0]        data_write_en,
    output logic [S_COUNT-1:0] hit_count,
    output logic [S_COUNT-1:0] miss_count,
    output logic [S_COUNT-1:0] wb_count
);
    cache_state_t state_q;
    cache_state_t state_d;

    logic        req_valid;
    logic        mem_resp_c;
    logic        pmem_read_c;
    logic        pmem_write_c;
    logic [31:0] pmem_addr_c;
    logic        miss_evt;
    logic        wb_evt;
    logic        unused_offset_bits;

    // Requests are masked while reset is held so no array write can slip out
    assign req_valid = rst && (bus.mem_read || bus.mem_write);
    assign unused_offset_bits = ^bus.mem_address[OFFSET_W-1:0];

    assign data_read  = 1'b1;
    assign tag_read   = 1'b1;
    assign valid_read = 1'b1;
    assign dirty_read = 1'b1;
    assign lru_read   = 1'b1;

    // State register; reset returns to IDLE asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d         = state_q;
        mem_resp_c      = 1'b0;
        pmem_read_c     = 1'b0;
        pmem_write_c    = 1'b0;
        pmem_addr_c     = '0;
        comb_data_read  = 1'b0;
        comb_tag_read   = 1'b0;
        comb_valid_read = 1'b0;
        comb_dirty_read = 1'b0;
        tag_load        = 1'b0;
        valid_load      = 1'b0;
        valid_datain    = 1'b0;
        dirty_load      = 1'b0;
        dirty_datain    = 1'b0;
        lru_load        = 1'b0;
        way_index_sel   = WAYSEL_HIT;
        data_write_en   = '0;
        miss_evt        = 1'b0;
        wb_evt          = 1'b0;
        case (state_q)
            IDLE: begin
                comb_data_read  = 1'b1;
                comb_tag_read   = 1'b1;
                comb_valid_read = 1'b1;
                comb_dirty_read = 1'b1;
                if (req_valid) begin
                    if (cache_hit) begin
                        mem_resp_c = 1'b1;
                        lru_load   = 1'b1;
                        if (bus.mem_write) begin
                            data_write_en = bus.mem_byte_enable256;
                            dirty_load    = 1'b1;
                            dirty_datain  = 1'b1;
                        end
                    end else begin
                        // Point the arrays at the victim so dirty_dataout/tag_dataout describe it
                        way_index_sel = WAYSEL_LRU;
                        miss_evt      = 1'b1;
                        state_d       = dirty_dataout ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                way_index_sel = WAYSEL_LRU;
                pmem_write_c  = 1'b1;
                pmem_addr_c   = {tag_dataout, bus.mem_address[OFFSET_W+SET_W-1:OFFSET_W],
                                 {OFFSET_W{1'b0}}};
                if (bus.pmem_resp) begin
                    wb_evt  = 1'b1;
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                way_index_sel = WAYSEL_LRU;
                pmem_read_c   = 1'b1;
                pmem_addr_c   = {bus.mem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
                if (bus.pmem_resp) begin
                    data_write_en = 32'hFFFF_FFFF;
                    tag_load      = 1'b1;
                    valid_load    = 1'b1;
                    valid_datain  = 1'b1;
                    dirty_load    = 1'b1;
                    dirty_datain  = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                way_index_sel = WAYSEL_WAY0;
                state_d       = IDLE;
            end
        endcase
    end

    assign bus.mem_resp     = mem_resp_c;
    assign bus.pmem_read    = pmem_read_c;
    assign bus.pmem_write   = pmem_write_c;
    assign bus.pmem_address = pmem_addr_c;

    sat_counter #(.WIDTH(S_COUNT)) u_hit_cnt (
        .clk(clk), .rst(rst), .inc(mem_resp_c), .count(hit_count)
    );
    sat_counter #(.WIDTH(S_COUNT)) u_miss_cnt (
        .clk(clk), .rst(rst), .inc(miss_evt), .count(miss_count)
    );
    sat_counter #(.WIDTH(S_COUNT)) u_wb_cnt (
        .clk(clk), .rst(rst), .inc(wb_evt), .count(wb_count)
    );
endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - scoreboard bench for cache_control with a small datapath model
module tb_cache_control;
    import cache_types_pkg::*;

    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_control_if bus();

    logic          cache_hit, dirty_dataout;
    logic [23:0]   tag_dataout;
    logic          data_read, tag_read, valid_read, dirty_read, lru_read;
    logic          comb_data_read, comb_tag_read, comb_valid_read, comb_dirty_read;
    logic          tag_load, valid_load, valid_datain, dirty_load, dirty_datain, lru_load;
    logic [1:0]    way_index_sel;
    logic [31:0]   data_write_en;
    logic [SW-1:0] hit_count, miss_count, wb_count;

    cache_control #(.S_COUNT(SW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cache_hit(cache_hit), .dirty_dataout(dirty_dataout), .tag_dataout(tag_dataout),
        .data_read(data_read), .tag_read(tag_read), .valid_read(valid_read),
        .dirty_read(dirty_read), .lru_read(lru_read),
        .comb_data_read(comb_data_read), .comb_tag_read(comb_tag_read),
        .comb_valid_read(comb_valid_read), .comb_dirty_read(comb_dirty_read),
        .tag_load(tag_load), .valid_load(valid_load), .valid_datain(valid_datain),
        .dirty_load(dirty_load), .dirty_datain(dirty_datain), .lru_load(lru_load),
        .way_index_sel(way_index_sel), .data_write_en(data_write_en),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Datapath model: tag/valid/dirty per way, LRU way index per set
    logic [23:0] m_tag   [8][2];
    logic        m_valid [8][2];
    logic        m_dirty [8][2];
    logic        m_lru   [8];
    logic        pl_clr = 1'b0, pl_en = 1'b0, pl_way = 1'b0, pl_dirty = 1'b0, pl_lru = 1'b0;
    logic [2:0]  pl_set = 3'd0;
    logic [23:0] pl_tag = 24'd0;
    logic [2:0]  a_set;
    logic [23:0] a_tag;
    logic        hit_way, sel_way;

    always_comb begin
        a_set     = bus.mem_address[7:5];
        a_tag     = bus.mem_address[31:8];
        hit_way   = m_valid[a_set][1] && (m_tag[a_set][1] == a_tag);
        cache_hit = (m_valid[a_set][0] && (m_tag[a_set][0] == a_tag)) || hit_way;
    end

    always_comb begin
        case (way_index_sel)
            WAYSEL_LRU:  sel_way = m_lru[a_set];
            WAYSEL_WAY0: sel_way = 1'b0;
            default:     sel_way = hit_way;
        endcase
        tag_dataout   = m_tag[a_set][sel_way];
        dirty_dataout = m_dirty[a_set][sel_way];
    end

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int s = 0; s < 8; s++) begin
                m_lru[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    m_tag[s][w]   <= 24'd0;
                    m_valid[s][w] <= 1'b0;
                    m_dirty[s][w] <= 1'b0;
                end
            end
        end else if (pl_en) begin
            m_tag[pl_set][pl_way]   <= pl_tag;
            m_valid[pl_set][pl_way] <= 1'b1;
            m_dirty[pl_set][pl_way] <= pl_dirty;
            m_lru[pl_set]           <= pl_lru;
        end else if (rst) begin
            if (tag_load)   m_tag[a_set][sel_way]   <= a_tag;
            if (valid_load) m_valid[a_set][sel_way] <= valid_datain;
            if (dirty_load) m_dirty[a_set][sel_way] <= dirty_datain;
            if (lru_load)   m_lru[a_set]            <= ~sel_way;
        end
    end

    // Physical memory: answers after pm_lat cycles of a held request
    int   pm_lat  = 2;
    int   pcnt    = 0;
    logic pm_resp = 1'b0;
    assign bus.pmem_resp = pm_resp;

    always @(posedge clk) begin
        #1;
        if (!rst || !(bus.pmem_read || bus.pmem_write)) begin
            pm_resp = 1'b0;
            pcnt    = 0;
        end else begin
            if (pm_resp) pcnt = 0;
            pcnt++;
            pm_resp = (pcnt == pm_lat);
        end
    end

    // Scoreboard
    typedef struct { logic wr; logic [31:0] be; } resp_exp_t;
    typedef struct { logic is_wb; logic [31:0] addr; } pm_exp_t;
    resp_exp_t resp_q[$];
    pm_exp_t   pm_q[$];
    resp_exp_t re;
    pm_exp_t   pe;
    int        rd_cycles = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.pmem_read) rd_cycles++;
            if (bus.mem_resp) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    re = resp_q.pop_front();
                    check("resp_dwe", data_write_en, re.wr ? re.be : 32'd0);
                    check("resp_dirty", 32'({dirty_load, dirty_datain}), re.wr ? 32'd3 : 32'd0);
                    check("resp_lru", 32'(lru_load), 32'd1);
                    check("resp_waysel", 32'(way_index_sel), 32'(WAYSEL_HIT));
                end
            end
            if (bus.pmem_resp && (bus.pmem_read || bus.pmem_write)) begin
                if (pm_q.size() == 0) begin
                    check("pm_unexpected", 32'd1, 32'd0);
                end else begin
                    pe = pm_q.pop_front();
                    check("pm_kind", 32'({bus.pmem_write, bus.pmem_read}), pe.is_wb ? 32'd2 : 32'd1);
                    check("pm_addr", bus.pmem_address, pe.addr);
                    if (pe.is_wb) begin
                        check("wb_no_array_write",
                              32'({tag_load, valid_load, dirty_load, |data_write_en}), 32'd0);
                    end else begin
                        check("fill_dwe", data_write_en, 32'hFFFF_FFFF);
                        check("fill_strobes",
                              32'({tag_load, valid_load, valid_datain, dirty_load, dirty_datain}),
                              32'b11110);
                    end
                end
            end
        end
    end

    task automatic preload(input logic [2:0] s, input logic w, input logic [23:0] t,
                           input logic d, input logic l);
        pl_set = s; pl_way = w; pl_tag = t; pl_dirty = d; pl_lru = l; pl_en = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic run_req(input logic wr, input logic [31:0] addr, input logic [31:0] be,
                           input logic exp_hit, output int cyc);
        logic got;
        got = 1'b0;
        cyc = 0;
        resp_q.push_back(resp_exp_t'{wr, be});
        @(posedge clk);
        #1;
        bus.mem_address        = addr;
        bus.mem_byte_enable256 = be;
        bus.mem_read           = !wr;
        bus.mem_write          = wr;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0 && !exp_hit) begin
                check("miss_no_resp", 32'(bus.mem_resp), 32'd0);
                check("miss_waysel", 32'(way_index_sel), 32'(WAYSEL_LRU));
            end
            if (bus.mem_resp) begin
                got = 1'b1;
                break;
            end
            cyc++;
        end
        if (!got) check("req_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    localparam logic [31:0] ADDR_A = {24'h0000A5, 3'd3, 5'h04};

    initial begin
        int cyc;
        int rd0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_address = 32'd0;
        bus.mem_byte_enable256 = 32'd0;
        pl_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1 pl_clr = 1'b0;

        @(negedge clk);
        check("rst_read_strobes", 32'({comb_data_read, comb_tag_read, comb_valid_read, comb_dirty_read,
              data_read, tag_read, valid_read, dirty_read, lru_read}), 32'h1FF);
        check("rst_ctl", 32'({bus.mem_resp, bus.pmem_read, bus.pmem_write, tag_load, valid_load,
              valid_datain, dirty_load, dirty_datain, lru_load}), 32'd0);
        check("rst_waysel", 32'(way_index_sel), 32'(WAYSEL_HIT));
        check("rst_dwe", data_write_en, 32'd0);
        check("rst_counters", 32'({hit_count, miss_count, wb_count}), 32'd0);

        @(posedge clk);
        #1 rst = 1'b1;

        preload(3'd3, 1'b1, 24'h0000A5, 1'b0, 1'b0);
        preload(3'd3, 1'b0, 24'h0000B5, 1'b0, 1'b0);
        run_req(1'b0, ADDR_A, 32'd0, 1'b1, cyc);
        check("rhit_latency", 32'(cyc), 32'd0);
        check("hit_count_1", 32'(hit_count), 32'd1);

        run_req(1'b1, ADDR_A, 32'h0000_000F, 1'b1, cyc);
        check("whit_latency", 32'(cyc), 32'd0);
        check("hit_count_2", 32'(hit_count), 32'd2);

        pm_lat = 5;
        rd0 = rd_cycles;
        pm_q.push_back(pm_exp_t'{1'b0, 32'h0000_1220});
        run_req(1'b0, 32'h0000_1234, 32'd0, 1'b0, cyc);
        check("cmiss_latency", 32'(cyc), 32'd6);
        check("cmiss_read_cycles", 32'(rd_cycles - rd0), 32'd5);
        check("miss_count_1", 32'(miss_count), 32'd1);
        check("hit_count_3", 32'(hit_count), 32'd3);

        preload(3'd2, 1'b0, 24'hABCDEF, 1'b1, 1'b0);
        pm_lat = 3;
        pm_q.push_back(pm_exp_t'{1'b1, 32'hABCD_EF40});
        pm_q.push_back(pm_exp_t'{1'b0, 32'h1111_1140});
        run_req(1'b0, 32'h1111_1140, 32'd0, 1'b0, cyc);
        check("dmiss_latency", 32'(cyc), 32'd7);
        check("wb_count_1", 32'(wb_count), 32'd1);
        check("miss_count_2", 32'(miss_count), 32'd2);

        pm_lat = 10;
        @(posedge clk);
        #1;
        bus.mem_address = 32'h0000_00A0;
        bus.mem_read    = 1'b1;
        repeat (4) @(negedge clk);
        check("alloc_pmem_read", 32'(bus.pmem_read), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_pmem", 32'({bus.pmem_read, bus.pmem_write}), 32'd0);
        check("rst_no_fill", 32'({tag_load, valid_load, dirty_load, |data_write_en}), 32'd0);
        check("rst_mid_counters", 32'({hit_count, miss_count, wb_count}), 32'd0);
        check("rst_mid_waysel", 32'(way_index_sel), 32'(WAYSEL_HIT));
        bus.mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_req(1'b0, ADDR_A, 32'd0, 1'b1, cyc);
            if (i == 14) check("hit_count_full", 32'(hit_count), 32'hF);
        end
        check("hit_count_sat", 32'(hit_count), 32'hF);
        check("miss_count_post_rst", 32'(miss_count), 32'd0);
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);
        check("pm_q_drained", 32'(pm_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end
endmodule
